// File: rtl/led_fade_driver.sv
// led_fade_driver: 8-channel PWM LED driver with linear per-channel fades toward a capped target.
// Define LED_FADE_GAMMA_EN to apply a square-law gamma correction in the duty latch.
module led_fade_driver #(
   parameter int PWM_BITS         = 8,
   parameter int FADE_STEP_CYCLES = 50_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          led_in,
   input  logic [PWM_BITS-1:0] bright_max,
   output logic [7:0]          led_out,
   output logic                busy
);
   localparam int TW = (FADE_STEP_CYCLES > 2) ? $clog2(FADE_STEP_CYCLES) : 1;
   localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);
   localparam logic [TW-1:0]       TICK_LAST = TW'(FADE_STEP_CYCLES - 1);
   logic [7:0]                     in_q;
   logic [PWM_BITS-1:0]            max_q, pwm_cnt;
   logic [TW-1:0]                  tick_cnt;
   logic                           tick;
   logic [7:0][PWM_BITS-1:0]       level, level_nxt, tgt, duty;
   logic [7:0]                     diff;

   function automatic logic [PWM_BITS-1:0] duty_map(input logic [PWM_BITS-1:0] l);
`ifdef LED_FADE_GAMMA_EN
      logic [2*PWM_BITS-1:0] p;
      p = {{PWM_BITS{1'b0}}, l} * {{PWM_BITS{1'b0}}, l};
      return (l == '1) ? '1 : p[2*PWM_BITS-1:PWM_BITS];
`else
      return l;
`endif
   endfunction

   assign tick = tick_cnt == TICK_LAST;

   // Step toward the current target only on tick; equality holds, so no overshoot or wrap.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         tgt[i]       = in_q[i] ? max_q : '0;
         diff[i]      = level[i] != tgt[i];
         level_nxt[i] = !tick ? level[i] :
                        (level[i] < tgt[i]) ? level[i] + 1'b1 :
                        (level[i] > tgt[i]) ? level[i] - 1'b1 : level[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q     <= '0;
         max_q    <= '0;
         pwm_cnt  <= '0;
         tick_cnt <= '0;
         level    <= '0;
         duty     <= '0;
         led_out  <= '0;
         busy     <= 1'b0;
      end else begin
         in_q     <= led_in;
         max_q    <= bright_max;
         pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         level    <= level_nxt;
         busy     <= |diff;
         // Duty only changes at the period boundary so each period has one constant width.
         for (int i = 0; i < 8; i++) begin
            if (pwm_cnt == PWM_LAST) duty[i] <= duty_map(level[i]);
            led_out[i] <= duty[i] > pwm_cnt;
         end
      end
   end
endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver: directed checks of fades, PWM duty, reversal, ceiling change and async reset.
module tb_led_fade_driver;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] led_in = '0;
   logic [7:0] bright_max = '0;
   logic [7:0] led_out;
   logic       busy;
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;

   led_fade_driver #(.PWM_BITS(8), .FADE_STEP_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .led_in(led_in), .bright_max(bright_max),
      .led_out(led_out), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_level(input int ch, input int val, input int bound, output int ok);
      ok = 0;
      for (int n = 0; n < bound && !ok; n++) begin
         step();
         if (dut.level[ch] == 8'(val)) ok = 1;
      end
   endtask

   task automatic measure(output int hi, output int edges, output int other);
      logic prev;
      hi = 0; edges = 0; other = 0;
      prev = led_out[0];
      for (int n = 0; n < 255; n++) begin
         step();
         hi += int'(led_out[0]);
         edges += int'(led_out[0] != prev);
         other += int'(led_out[7:1] != 7'd0);
         prev = led_out[0];
      end
   endtask

   task automatic settle(input logic [7:0] lvl, output int hi);
      int ok, e, o;
      led_in = 8'h01;
      bright_max = lvl;
      repeat (3) step();
      ok = 0;
      for (int n = 0; n < 1200 && !ok; n++) begin
         step();
         if (!busy) ok = 1;
      end
      chk("settle_busy_low", ok, 1);
      repeat (520) step();
      measure(hi, e, o);
   endtask

   logic [7:0] g_lvl [3] = '{8'd128, 8'd255, 8'd15};
`ifdef LED_FADE_GAMMA_EN
   int         g_exp [3] = '{64, 255, 0};
`else
   int         g_exp [3] = '{128, 255, 15};
`endif

   initial begin
      int ok, c1, c255, hi, edges, other, prev, mx, first, mono;
      #12;
      chk("reset_led_out", int'(led_out), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_level0", int'(dut.level[0]), 0);
      rst_n = 1'b1;
      step();
      // Full-scale ramp on channel 0
      led_in = 8'h01;
      bright_max = 8'd255;
      wait_level(0, 1, 20, ok);
      chk("ramp_start", ok, 1);
      c1 = cyc;
      wait_level(0, 255, 1100, ok);
      chk("ramp_full", ok, 1);
      c255 = cyc;
      chk("ramp_cycles", c255 - c1, 254 * 4);
      chk("busy_at_full", int'(busy), 1);
      step();
      chk("busy_after_full", int'(busy), 0);
      repeat (300) step();
      measure(hi, edges, other);
      chk("full_on_high", hi, 255);
      chk("full_on_others", other, 0);
      // Steady level 100
      settle(8'd100, hi);
      chk("lvl100_level", int'(dut.level[0]), 100);
      measure(hi, edges, other);
      chk("lvl100_high", hi, 100);
      chk("lvl100_edges", edges, 2);
      chk("lvl100_others", other, 0);
      // Mid-fade reversal on channel 3
      led_in = 8'h08;
      bright_max = 8'd200;
      wait_level(3, 60, 400, ok);
      chk("rev_reach60", ok, 1);
      led_in = 8'h00;
      prev = 60; mx = 60; first = -1; mono = 1; ok = 0;
      for (int n = 0; n < 400 && !ok; n++) begin
         step();
         if (int'(dut.level[3]) > prev) mono = 0;
         if (int'(dut.level[3]) > mx) mx = int'(dut.level[3]);
         if (first < 0 && int'(dut.level[3]) != 60) first = int'(dut.level[3]);
         prev = int'(dut.level[3]);
         if (dut.level[3] == 8'd0) ok = 1;
      end
      chk("rev_first", first, 59);
      chk("rev_monotonic", mono, 1);
      chk("rev_max_le_61", int'(mx <= 61), 1);
      chk("rev_reach0", ok, 1);
      // Ceiling lowered from 200 to 50
      led_in = 8'h01;
      bright_max = 8'd200;
      wait_level(0, 200, 1000, ok);
      chk("cap_reach200", ok, 1);
      repeat (2) step();
      chk("cap_busy_idle", int'(busy), 0);
      bright_max = 8'd50;
      repeat (3) step();
      chk("cap_busy_fall", int'(busy), 1);
      prev = int'(dut.level[0]); mono = 1; ok = 0;
      for (int n = 0; n < 700 && !ok; n++) begin
         step();
         if (int'(dut.level[0]) != prev && int'(dut.level[0]) != prev - 1) mono = 0;
         if (int'(dut.level[0]) != prev && !busy) mono = 0;
         prev = int'(dut.level[0]);
         if (dut.level[0] == 8'd50) ok = 1;
      end
      chk("cap_reach50", ok, 1);
      chk("cap_unit_steps", mono, 1);
      repeat (2) step();
      chk("cap_busy_done", int'(busy), 0);
      repeat (40) step();
      chk("cap_hold50", int'(dut.level[0]), 50);
      // Asynchronous reset mid-fade
      bright_max = 8'd255;
      wait_level(0, 128, 400, ok);
      chk("rst_reach128", ok, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_led_out", int'(led_out), 0);
      chk("rst_async_busy", int'(busy), 0);
      chk("rst_async_level", int'(dut.level[0]), 0);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      step();
      chk("rst_restart0", int'(dut.level[0]), 0);
      first = -1;
      for (int n = 0; n < 20 && first < 0; n++) begin
         step();
         if (dut.level[0] != 8'd0) first = int'(dut.level[0]);
      end
      chk("rst_restart_first", first, 1);
      // Duty mapping at selected levels
      for (int k = 0; k < 3; k++) begin
         settle(g_lvl[k], hi);
         chk($sformatf("duty_lvl%0d", g_lvl[k]), hi, g_exp[k]);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
